// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam logic       RW_WR        = 1'b0;
  localparam logic       RW_RD        = 1'b1;
  localparam logic [6:0] DEF_DEV_ADDR = 7'h66;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and flags SCL edges and START/STOP.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Chains reset to the idle (pulled-up) bus level so release from reset sees no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target serving a byte-wide register file with an auto-incrementing pointer.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
  parameter int         REG_AW      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int DEPTH = 2 ** REG_AW;

  logic              sda_s, scl_rise, scl_fall, start, stop;
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [6:0]        shreg;
  logic [7:0]        tx;
  logic [7:0]        rx_byte;
  logic [REG_AW-1:0] ptr;
  logic [REG_AW-1:0] ptr_nxt;
  logic              rw;
  logic              phase;
  logic [7:0]        regs [DEPTH];

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign rx_byte = {shreg, sda_s};
  assign ptr_nxt = ptr + REG_AW'(1);

  // phase marks the second half of a two-fall sequence: ACK driven, or last read bit shifted out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= 3'd7;
      shreg    <= '0;
      tx       <= '0;
      ptr      <= '0;
      rw       <= RW_WR;
      phase    <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (start) begin
        state   <= S_ADDR;
        bit_cnt <= 3'd7;
        shreg   <= '0;
        phase   <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop) begin
        state  <= S_IDLE;
        phase  <= 1'b0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_REG, S_WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) begin
                phase <= 1'b0;
                case (state)
                  S_ADDR: begin
                    if (rx_byte[7:1] == DEV_ADDR) begin
                      state <= S_ADDR_ACK;
                      busy  <= 1'b1;
                      rw    <= rx_byte[0];
                    end else begin
                      state <= S_IGNORE;
                    end
                  end
                  S_REG: begin
                    ptr   <= rx_byte[REG_AW-1:0];
                    state <= S_REG_ACK;
                  end
                  S_WDATA: begin
                    regs[ptr] <= rx_byte;
                    wr_valid  <= 1'b1;
                    wr_addr   <= ptr;
                    wr_data   <= rx_byte;
                    ptr       <= ptr_nxt;
                    state     <= S_WDATA_ACK;
                  end
                  default: ;
                endcase
              end
            end
          end
          S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= 1'b1;
                phase  <= 1'b1;
              end else begin
                phase   <= 1'b0;
                bit_cnt <= 3'd7;
                if (state == S_ADDR_ACK && rw == RW_RD) begin
                  tx     <= regs[ptr];
                  sda_oe <= ~regs[ptr][7];
                  state  <= S_RDATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= (state == S_ADDR_ACK) ? S_REG : S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (scl_fall) begin
              if (phase) begin
                sda_oe <= 1'b0;
                phase  <= 1'b0;
                state  <= S_RDATA_ACK;
              end else begin
                sda_oe <= ~tx[7];
              end
            end else if (scl_rise) begin
              tx      <= {tx[6:0], 1'b0};
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) phase <= 1'b1;
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s == ACK) begin
                ptr     <= ptr_nxt;
                tx      <= regs[ptr_nxt];
                bit_cnt <= 3'd7;
                state   <= S_RDATA;
              end else begin
                busy  <= 1'b0;
                state <= S_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Scoreboard bench: a behavioural I2C master drives directed transactions against i2c_slave_regs.
module tb_i2c_slave_regs;

  localparam int TQ = 100;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  exp_t        exp_q[$];
  logic [7:0]  act_q[$];
  logic [11:0] exp_wr[$];
  int          nchecks = 0;
  int          nerrors = 0;
  int          oe_cnt = 0;
  int          oe_base;
  exp_t        e_m;
  logic [7:0]  a_m;
  logic [11:0] w_m;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regs #(.DEV_ADDR(7'b1100110), .REG_AW(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every wr_valid pulse and every observed bus response against the queues.
  always @(negedge clk) begin
    if (sda_oe) oe_cnt++;
    if (wr_valid) begin
      if (exp_wr.size() == 0) begin
        nchecks++;
        nerrors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", wr_addr, wr_data);
      end else begin
        w_m = exp_wr.pop_front();
        check("wr_addr", {4'd0, wr_addr}, {4'd0, w_m[11:8]});
        check("wr_data", wr_data, w_m[7:0]);
      end
    end
    while (act_q.size() > 0) begin
      a_m = act_q.pop_front();
      if (exp_q.size() == 0) begin
        nchecks++;
        nerrors++;
        $display("FAIL unexpected_obs: got %0h, required nothing", a_m);
      end else begin
        e_m = exp_q.pop_front();
        check(e_m.name, a_m, e_m.val);
      end
    end
  end

  task automatic obs(input string nm, input logic [7:0] exp, input logic [7:0] act);
    exp_t e;
    e.name = nm;
    e.val  = exp;
    exp_q.push_back(e);
    act_q.push_back(act);
  endtask

  task automatic send_bit(input logic b, output logic r);
    sda_m = b;
    #TQ scl_m = 1'b1;
    #TQ r = sda_bus;
    #TQ scl_m = 1'b0;
    #TQ;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #TQ scl_m = 1'b1;
    #TQ sda_m = 1'b0;
    #TQ scl_m = 1'b0;
    #TQ;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #TQ scl_m = 1'b1;
    #TQ sda_m = 1'b1;
    #TQ;
  endtask

  task automatic wr_b(input logic [7:0] d, input logic exp_ack, input string nm);
    logic r;
    exp_t e;
    e.name = nm;
    e.val  = {7'd0, exp_ack};
    exp_q.push_back(e);
    for (int i = 7; i >= 0; i--) send_bit(d[i], r);
    send_bit(1'b1, r);
    act_q.push_back({7'd0, r});
  endtask

  task automatic rd_b(input logic [7:0] exp_d, input logic mack, input string nm);
    logic [7:0] d;
    logic       r;
    exp_t       e;
    e.name = nm;
    e.val  = exp_d;
    exp_q.push_back(e);
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      d[i] = r;
    end
    send_bit(mack, r);
    act_q.push_back(d);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic r;
    logic [7:0] cc;
    cc = 8'hCC;
    repeat (3) @(posedge clk);
    #1;
    obs("rst_sda_oe", 8'h00, {7'd0, sda_oe});
    obs("rst_busy", 8'h00, {7'd0, busy});
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs("idle_wr_valid", 8'h00, {7'd0, wr_valid});
    obs("idle_wr_addr", 8'h00, {4'd0, wr_addr});
    obs("idle_wr_data", 8'h00, wr_data);

    // Single-byte write to reg 3
    i2c_start();
    wr_b(8'hCC, 1'b0, "ack_addr_w");
    wr_b(8'h03, 1'b0, "ack_reg");
    exp_wr.push_back({4'h3, 8'h5A});
    wr_b(8'h5A, 1'b0, "ack_data");
    obs("busy_in_write", 8'h01, {7'd0, busy});
    i2c_stop();
    obs("busy_after_stop_w", 8'h00, {7'd0, busy});

    // Register read through repeated START
    i2c_start();
    wr_b(8'hCC, 1'b0, "ack_addr_w2");
    wr_b(8'h03, 1'b0, "ack_reg2");
    i2c_start();
    wr_b(8'hCD, 1'b0, "ack_addr_r");
    obs("busy_in_read", 8'h01, {7'd0, busy});
    rd_b(8'h5A, 1'b1, "rdata_reg3");
    obs("oe_after_nack", 8'h00, {7'd0, sda_oe});
    i2c_stop();
    obs("busy_after_stop_r", 8'h00, {7'd0, busy});

    // Foreign address: no ACK, no writes, never busy
    oe_base = oe_cnt;
    i2c_start();
    wr_b(8'hCA, 1'b1, "nack_wrong_addr");
    wr_b(8'h03, 1'b1, "nack_wrong_reg");
    wr_b(8'h77, 1'b1, "nack_wrong_data");
    obs("busy_wrong", 8'h00, {7'd0, busy});
    i2c_stop();
    obs("oe_wrong_count", 8'h00, {7'd0, oe_cnt != oe_base});

    // Burst write wrapping 0xF -> 0x0, then burst read back
    i2c_start();
    wr_b(8'hCC, 1'b0, "ack_addr_bw");
    wr_b(8'h0F, 1'b0, "ack_reg_bw");
    exp_wr.push_back({4'hF, 8'h11});
    wr_b(8'h11, 1'b0, "ack_bw0");
    exp_wr.push_back({4'h0, 8'h22});
    wr_b(8'h22, 1'b0, "ack_bw1");
    i2c_stop();
    i2c_start();
    wr_b(8'hCC, 1'b0, "ack_addr_br");
    wr_b(8'h0F, 1'b0, "ack_reg_br");
    i2c_start();
    wr_b(8'hCD, 1'b0, "ack_addr_br_r");
    rd_b(8'h11, 1'b0, "rdata_burst0");
    rd_b(8'h22, 1'b1, "rdata_burst1");
    i2c_stop();

    // Reset while the address ACK is held
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(cc[i], r);
    sda_m = 1'b1;
    #TQ scl_m = 1'b1;
    #TQ;
    obs("oe_before_rst", 8'h01, {7'd0, sda_oe});
    rst = 1'b1;
    #1;
    obs("oe_async_rst", 8'h00, {7'd0, sda_oe});
    obs("busy_async_rst", 8'h00, {7'd0, busy});
    repeat (2) @(posedge clk);
    rst = 1'b0;
    #TQ scl_m = 1'b0;
    #TQ;
    i2c_stop();
    i2c_start();
    wr_b(8'hCC, 1'b0, "ack_addr_post_rst");
    wr_b(8'h02, 1'b0, "ack_reg_post_rst");
    exp_wr.push_back({4'h2, 8'h3C});
    wr_b(8'h3C, 1'b0, "ack_data_post_rst");
    i2c_stop();
    i2c_start();
    wr_b(8'hCC, 1'b0, "ack_addr_rb");
    wr_b(8'h02, 1'b0, "ack_reg_rb");
    i2c_start();
    wr_b(8'hCD, 1'b0, "ack_addr_rb_r");
    rd_b(8'h3C, 1'b0, "rdata_reg2");
    rd_b(8'h00, 1'b1, "rdata_reg3_cleared");
    i2c_stop();

    // Repeated START after 4 data bits discards the partial byte
    i2c_start();
    wr_b(8'hCC, 1'b0, "ack_addr_part");
    wr_b(8'h05, 1'b0, "ack_reg_part");
    send_bit(1'b1, r);
    send_bit(1'b0, r);
    send_bit(1'b1, r);
    send_bit(1'b0, r);
    i2c_start();
    wr_b(8'hCC, 1'b0, "ack_addr_after_rs");
    wr_b(8'h05, 1'b0, "ack_reg_after_rs");
    exp_wr.push_back({4'h5, 8'h77});
    wr_b(8'h77, 1'b0, "ack_data_after_rs");
    i2c_stop();

    for (int i = 0; i < 200; i++) begin
      if (act_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    check("pending_obs", 8'(exp_q.size()), 8'd0);
    check("pending_writes", 8'(exp_wr.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
